stopwatch_ctrl: RTL and testbench
=================================

# stopwatch_ctrl

Control FSM and tick prescaler for the stopwatch counter chain. It turns one-cycle keyboard command pulses (start/stop, lap, clear) into the `inc` enable for the least-significant BCD digit counter and the `is_reset` pulse shared by all digit counters. It also manages lap freeze and overflow saturation. It sits between the PS/2 key decoder and the cascaded digit counters.

## Interface
- `CLK_HZ`, 100_000_000, system clock frequency.
- `TICK_HZ`, 100, count rate of the least-significant digit (1/100 s).
- `DIV`, derived as CLK_HZ/TICK_HZ. Must be ≥2; elaboration error otherwise.

Ports:
- `clk` in 1: system clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `cmd_ss` in 1: start/stop command, one-cycle pulse.
- `cmd_lap` in 1: lap command, one-cycle pulse.
- `cmd_clr` in 1: clear command, one-cycle pulse.
- `at_max` in 1: counter chain currently holds its maximum value (combinational from the digits).
- `inc` out 1: one-cycle count enable to the LSD counter.
- `is_reset` out 1: one-cycle synchronous clear to all digit counters.
- `running` out 1: high in RUN and LAP.
- `lap_hold` out 1: display freeze, high in LAP.
- `lap_strobe` out 1: one-cycle pulse on entry to LAP; display latch captures the digits.
- `ovf` out 1: sticky overflow flag.

## Operation
- States: IDLE, RUN, LAP, STOP.
- Command priority: `cmd_clr` > `cmd_ss` > `cmd_lap`.
  - Only the highest-priority asserted command is evaluated.
  - If that command is illegal in the current state, nothing happens; lower-priority commands in the same cycle are dropped.
- State transitions:
  - IDLE: `ss` → RUN. `clr` → IDLE with `is_reset` pulse. `lap` ignored.
  - RUN: `ss` → STOP. `lap` → LAP with `lap_strobe` pulse. `clr` ignored.
  - LAP: `lap` → RUN, releasing `lap_hold`. `ss` → STOP, releasing `lap_hold`. `clr` ignored. Counting continues in LAP.
  - STOP: `ss` → RUN. `clr` → IDLE with `is_reset` pulse; clears `ovf` and the prescaler. `lap` ignored.
- Prescaler:
  - Counts 0..DIV-1 only in RUN/LAP; at DIV-1 it wraps to 0.
  - Holds its value in STOP, so a resume continues the partial tick.
  - Zeroed on clear and on reset.
- Tick handling, at the wrap:
  - If `at_max`=0: `inc`=1 for exactly one cycle.
  - If `at_max`=1: `inc` is suppressed, the FSM goes to STOP, `ovf` is set, and `lap_hold` drops.
  - The count saturates and never wraps past maximum.
- A tick wrap coinciding with `ss` (RUN→STOP): `inc` still fires for that tick.
- A tick wrap coinciding with `clr` in STOP cannot occur, because the prescaler is frozen in STOP.
- `is_reset` and `inc` are never high in the same cycle.
- Reset values: state IDLE, prescaler 0, all outputs 0.
- Asynchronous reset mid-count: counters are not cleared by this block. The digit counters carry their own reset.

## Timing
- All outputs are registered.
- A command sampled at edge k takes effect in state and outputs after edge k; outputs are visible in cycle k+1.
- First `inc` is exactly DIV cycles after the edge that samples `cmd_ss` from IDLE. After that, `inc` repeats every DIV cycles.
- `is_reset` and `lap_strobe` are exactly 1 cycle wide.
- `at_max` is sampled on the same edge as the prescaler wrap.

## Structure
- Shared package `stopwatch_pkg`:
  - State enum (IDLE, RUN, LAP, STOP).
  - Default CLK_HZ/TICK_HZ constants.
  - Prescaler width computed as $clog2(DIV).
- Sub-module `tick_prescaler`:
  - Inputs: enable, clear.
  - Output: a wrap pulse.
  - Parameter: DIV.
- The FSM and output registers stay in `stopwatch_ctrl`.

## Test plan
All scenarios use CLK_HZ=1000, TICK_HZ=100, so DIV=10.
- **Basic run:** reset, `cmd_ss` at cycle 5 → `running`=1 at cycle 6; `inc` pulses at cycles 15, 25, 35; `is_reset`=0 throughout.
- **Stop/resume with partial tick:** run 14 cycles past the start (4 into the second tick), `cmd_ss`, wait 50 cycles with no `inc`, `cmd_ss` → next `inc` 6 cycles after resume.
- **Lap:** in RUN, `cmd_lap` → `lap_strobe` one cycle, `lap_hold`=1, `inc` continues; second `cmd_lap` → `lap_hold`=0; `cmd_ss` in LAP → STOP with `lap_hold`=0.
- **Clear legality:** `cmd_clr` in RUN → no `is_reset`, still running; in STOP → one-cycle `is_reset`, state IDLE, prescaler 0, next start gives first `inc` after exactly 10 cycles.
- **Simultaneous commands:** in STOP, `cmd_clr`+`cmd_ss` together → IDLE with `is_reset`, not RUN; in IDLE, `cmd_lap`+`cmd_ss` → RUN, no `lap_strobe`.
- **Overflow and reset:** hold `at_max`=1 in RUN → at the next wrap there is no `inc`, `running`=0, `ovf`=1; `cmd_clr` → `ovf`=0. Separately, assert `rst` low mid-tick → all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// ---------------------------------------------------------------------------
// stopwatch_pkg
//   Shared definitions for the stopwatch control slice:
//     - state_e         : control FSM state encoding (IDLE, RUN, LAP, STOP)
//     - CLK_HZ_DEFAULT  : default system clock frequency
//     - TICK_HZ_DEFAULT : default count rate of the least-significant digit
//     - presc_width()   : prescaler counter width for a given divide ratio
// ---------------------------------------------------------------------------
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LAP  = 2'd2,
        STOP = 2'd3
    } state_e;

    localparam int unsigned CLK_HZ_DEFAULT  = 100_000_000;
    localparam int unsigned TICK_HZ_DEFAULT = 100;

    // Width able to hold 0..div-1. Clamped to 1 so that an illegal divide
    // ratio still yields a legal vector while the elaboration check reports it.
    function automatic int unsigned presc_width(input int unsigned div);
        if (div < 2) begin
            return 1;
        end
        return $clog2(div);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// ---------------------------------------------------------------------------
// tick_prescaler
//   Divides the system clock down to the least-significant-digit tick.
//   The counter runs 0..DIV-1; wrap_o is high while the count sits at DIV-1,
//   and the following edge returns the count to 0.
//
//   Ports:
//     clk    in  system clock, rising-edge
//     rst_n  in  asynchronous active-low reset, zeroes the count
//     en_i   in  advance the count on this edge
//     clr_i  in  synchronous clear to 0 (dominates everything else)
//     wrap_o out count is at DIV-1; the tick is consumed on the next edge
// ---------------------------------------------------------------------------
module tick_prescaler
    import stopwatch_pkg::*;
#(
    parameter int unsigned DIV = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic clr_i,
    output logic wrap_o
);

    localparam int unsigned W = presc_width(DIV);
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    generate
        if (DIV < 2) begin : g_div_check
            $error("tick_prescaler: DIV must be at least 2");
        end
    endgenerate

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign wrap_o = (cnt_q == LAST);

    // The wrap back to 0 does not depend on en_i: DIV-1 is only ever reached
    // on an enabled edge, so a stop arriving on the wrap edge still consumes
    // that tick and the count restarts cleanly from 0 on resume.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (wrap_o) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// ---------------------------------------------------------------------------
// stopwatch_ctrl
//   Control FSM for the stopwatch digit chain. Converts one-cycle keyboard
//   command pulses into the LSD count enable and the shared digit clear,
//   and handles lap freeze and overflow saturation.
//
//   Parameters:
//     CLK_HZ   system clock frequency
//     TICK_HZ  LSD count rate; CLK_HZ/TICK_HZ must be at least 2
//
//   Ports:
//     clk        in  system clock, rising-edge
//     rst        in  asynchronous active-low reset
//     cmd_ss     in  start/stop command pulse
//     cmd_lap    in  lap command pulse
//     cmd_clr    in  clear command pulse
//     at_max     in  digit chain holds its maximum value
//     inc        out one-cycle count enable to the LSD counter
//     is_reset   out one-cycle synchronous clear to all digit counters
//     running    out high in RUN and LAP
//     lap_hold   out display freeze, high in LAP
//     lap_strobe out one-cycle pulse on entry to LAP
//     ovf        out sticky overflow flag, cleared by a clear from STOP
// ---------------------------------------------------------------------------
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned CLK_HZ  = CLK_HZ_DEFAULT,
    parameter int unsigned TICK_HZ = TICK_HZ_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic cmd_ss,
    input  logic cmd_lap,
    input  logic cmd_clr,
    input  logic at_max,
    output logic inc,
    output logic is_reset,
    output logic running,
    output logic lap_hold,
    output logic lap_strobe,
    output logic ovf
);

    localparam int unsigned DIV = CLK_HZ / TICK_HZ;

    state_e state_q, state_d;
    logic   inc_q, inc_d;
    logic   is_reset_q, is_reset_d;
    logic   running_q, running_d;
    logic   lap_hold_q, lap_hold_d;
    logic   lap_strobe_q, lap_strobe_d;
    logic   ovf_q, ovf_d;

    logic   tick_wrap;
    logic   presc_en;
    logic   presc_clr;

    // The prescaler advances on every edge whose resulting state is RUN or
    // LAP, including the entry edge itself; this puts the first inc exactly
    // DIV cycles after the start command and keeps a partial tick across STOP.
    assign presc_en  = (state_d == RUN) || (state_d == LAP);
    assign presc_clr = is_reset_d;

    tick_prescaler #(
        .DIV (DIV)
    ) u_presc (
        .clk    (clk),
        .rst_n  (rst),
        .en_i   (presc_en),
        .clr_i  (presc_clr),
        .wrap_o (tick_wrap)
    );

    always_comb begin
        state_d      = state_q;
        inc_d        = 1'b0;
        is_reset_d   = 1'b0;
        lap_strobe_d = 1'b0;
        ovf_d        = ovf_q;

        // Only the highest-priority command is evaluated; if it is illegal
        // in the current state the lower ones are dropped, not promoted.
        if (cmd_clr) begin
            if (state_q == IDLE || state_q == STOP) begin
                state_d    = IDLE;
                is_reset_d = 1'b1;
                ovf_d      = 1'b0;
            end
        end else if (cmd_ss) begin
            case (state_q)
                IDLE:    state_d = RUN;
                RUN:     state_d = STOP;
                LAP:     state_d = STOP;
                STOP:    state_d = RUN;
                default: state_d = state_q;
            endcase
        end else if (cmd_lap) begin
            if (state_q == RUN) begin
                state_d      = LAP;
                lap_strobe_d = 1'b1;
            end else if (state_q == LAP) begin
                state_d = RUN;
            end
        end

        // A wrap only occurs in RUN/LAP, where clear is ignored, so inc and
        // is_reset cannot coincide. Saturation overrides any command outcome.
        if (tick_wrap) begin
            if (at_max) begin
                state_d      = STOP;
                ovf_d        = 1'b1;
                lap_strobe_d = 1'b0;
            end else begin
                inc_d = 1'b1;
            end
        end

        running_d  = (state_d == RUN) || (state_d == LAP);
        lap_hold_d = (state_d == LAP);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            inc_q        <= 1'b0;
            is_reset_q   <= 1'b0;
            running_q    <= 1'b0;
            lap_hold_q   <= 1'b0;
            lap_strobe_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            inc_q        <= inc_d;
            is_reset_q   <= is_reset_d;
            running_q    <= running_d;
            lap_hold_q   <= lap_hold_d;
            lap_strobe_q <= lap_strobe_d;
            ovf_q        <= ovf_d;
        end
    end

    assign inc        = inc_q;
    assign is_reset   = is_reset_q;
    assign running    = running_q;
    assign lap_hold   = lap_hold_q;
    assign lap_strobe = lap_strobe_q;
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
module tb_stopwatch_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic cmd_ss = 1'b0;
    logic cmd_lap = 1'b0;
    logic cmd_clr = 1'b0;
    logic at_max = 1'b0;
    logic inc, is_reset, running, lap_hold, lap_strobe, ovf;

    int unsigned vectors = 0;
    int unsigned errors  = 0;
    int unsigned cyc     = 0;

    int unsigned exp_inc[$];
    int unsigned obs_inc[$];
    int unsigned obs_rst[$];
    bit          both_seen = 1'b0;

    stopwatch_ctrl #(
        .CLK_HZ  (1000),
        .TICK_HZ (100)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_ss     (cmd_ss),
        .cmd_lap    (cmd_lap),
        .cmd_clr    (cmd_clr),
        .at_max     (at_max),
        .inc        (inc),
        .is_reset   (is_reset),
        .running    (running),
        .lap_hold   (lap_hold),
        .lap_strobe (lap_strobe),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record output pulses with the number of rising edges seen so far.
    always @(negedge clk) begin
        if (inc) obs_inc.push_back(cyc);
        if (is_reset) obs_rst.push_back(cyc);
        if (inc && is_reset) both_seen = 1'b1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic run_to(input int unsigned t);
        while (cyc < t) tick();
    endtask

    task automatic apply_reset();
        cmd_ss = 1'b0; cmd_lap = 1'b0; cmd_clr = 1'b0; at_max = 1'b0;
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        exp_inc.delete();
        obs_inc.delete();
        obs_rst.delete();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        vectors++; if (inc !== 1'b0)        begin errors++; $display("FAIL reset_inc: got %b, expected 0", inc); end
        vectors++; if (is_reset !== 1'b0)   begin errors++; $display("FAIL reset_is_reset: got %b, expected 0", is_reset); end
        vectors++; if (running !== 1'b0)    begin errors++; $display("FAIL reset_running: got %b, expected 0", running); end
        vectors++; if (lap_hold !== 1'b0)   begin errors++; $display("FAIL reset_lap_hold: got %b, expected 0", lap_hold); end
        vectors++; if (lap_strobe !== 1'b0) begin errors++; $display("FAIL reset_lap_strobe: got %b, expected 0", lap_strobe); end
        vectors++; if (ovf !== 1'b0)        begin errors++; $display("FAIL reset_ovf: got %b, expected 0", ovf); end
        rst = 1'b1;
    endtask

    task automatic test_basic_run();
        int unsigned c, e, o;
        apply_reset();
        c = cyc;
        cmd_ss = 1'b1; tick(); cmd_ss = 1'b0;
        vectors++; if (running !== 1'b1) begin errors++; $display("FAIL basic_running: got %b, expected 1", running); end
        exp_inc.push_back(c + 10); exp_inc.push_back(c + 20); exp_inc.push_back(c + 30);
        run_to(c + 32);
        while (exp_inc.size() != 0) begin
            e = exp_inc.pop_front();
            vectors++;
            if (obs_inc.size() == 0) begin errors++; $display("FAIL basic_inc: got no pulse, expected at cycle %0d", e); end
            else begin
                o = obs_inc.pop_front();
                if (o !== e) begin errors++; $display("FAIL basic_inc: got cycle %0d, expected cycle %0d", o, e); end
            end
        end
        vectors++; if (obs_inc.size() != 0) begin errors++; $display("FAIL basic_extra_inc: got %0d extra, expected 0", obs_inc.size()); end
        vectors++; if (obs_rst.size() != 0) begin errors++; $display("FAIL basic_is_reset: got %0d pulses, expected 0", obs_rst.size()); end
    endtask

    task automatic test_stop_resume();
        int unsigned c, r, e, o;
        apply_reset();
        c = cyc;
        cmd_ss = 1'b1; tick(); cmd_ss = 1'b0;
        exp_inc.push_back(c + 10);
        run_to(c + 14);
        cmd_ss = 1'b1; tick(); cmd_ss = 1'b0;
        vectors++; if (running !== 1'b0) begin errors++; $display("FAIL stop_running: got %b, expected 0", running); end
        run_to(c + 65);
        r = cyc;
        cmd_ss = 1'b1; tick(); cmd_ss = 1'b0;
        exp_inc.push_back(r + 6); exp_inc.push_back(r + 16);
        run_to(r + 18);
        while (exp_inc.size() != 0) begin
            e = exp_inc.pop_front();
            vectors++;
            if (obs_inc.size() == 0) begin errors++; $display("FAIL resume_inc: got no pulse, expected at cycle %0d", e); end
            else begin
                o = obs_inc.pop_front();
                if (o !== e) begin errors++; $display("FAIL resume_inc: got cycle %0d, expected cycle %0d", o, e); end
            end
        end
        vectors++; if (obs_inc.size() != 0) begin errors++; $display("FAIL resume_extra_inc: got %0d extra, expected 0", obs_inc.size()); end
    endtask

    task automatic test_lap();
        int unsigned c, e, o;
        apply_reset();
        c = cyc;
        cmd_ss = 1'b1; tick(); cmd_ss = 1'b0;
        exp_inc.push_back(c + 10); exp_inc.push_back(c + 20); exp_inc.push_back(c + 30);
        run_to(c + 13);
        cmd_lap = 1'b1; tick(); cmd_lap = 1'b0;
        vectors++; if (lap_strobe !== 1'b1) begin errors++; $display("FAIL lap_strobe_on: got %b, expected 1", lap_strobe); end
        vectors++; if (lap_hold !== 1'b1)   begin errors++; $display("FAIL lap_hold_on: got %b, expected 1", lap_hold); end
        tick();
        vectors++; if (lap_strobe !== 1'b0) begin errors++; $display("FAIL lap_strobe_width: got %b, expected 0", lap_strobe); end
        vectors++; if (running !== 1'b1)    begin errors++; $display("FAIL lap_running: got %b, expected 1", running); end
        run_to(c + 27);
        cmd_lap = 1'b1; tick(); cmd_lap = 1'b0;
        vectors++; if (lap_hold !== 1'b0) begin errors++; $display("FAIL lap_release: got %b, expected 0", lap_hold); end
        run_to(c + 33);
        cmd_lap = 1'b1; tick(); cmd_lap = 1'b0;
        run_to(c + 36);
        cmd_ss = 1'b1; tick(); cmd_ss = 1'b0;
        vectors++; if (lap_hold !== 1'b0) begin errors++; $display("FAIL lap_ss_hold: got %b, expected 0", lap_hold); end
        vectors++; if (running !== 1'b0)  begin errors++; $display("FAIL lap_ss_running: got %b, expected 0", running); end
        run_to(c + 45);
        while (exp_inc.size() != 0) begin
            e = exp_inc.pop_front();
            vectors++;
            if (obs_inc.size() == 0) begin errors++; $display("FAIL lap_inc: got no pulse, expected at cycle %0d", e); end
            else begin
                o = obs_inc.pop_front();
                if (o !== e) begin errors++; $display("FAIL lap_inc: got cycle %0d, expected cycle %0d", o, e); end
            end
        end
        vectors++; if (obs_inc.size() != 0) begin errors++; $display("FAIL lap_extra_inc: got %0d extra, expected 0", obs_inc.size()); end
    endtask

    task automatic test_clear();
        int unsigned c, e, o;
        apply_reset();
        c = cyc;
        cmd_ss = 1'b1; tick(); cmd_ss = 1'b0;
        exp_inc.push_back(c + 10);
        run_to(c + 5);
        cmd_clr = 1'b1; tick(); cmd_clr = 1'b0;
        vectors++; if (is_reset !== 1'b0) begin errors++; $display("FAIL clr_run_is_reset: got %b, expected 0", is_reset); end
        vectors++; if (running !== 1'b1)  begin errors++; $display("FAIL clr_run_running: got %b, expected 1", running); end
        run_to(c + 15);
        cmd_ss = 1'b1; tick(); cmd_ss = 1'b0;
        run_to(c + 20);
        cmd_clr = 1'b1; tick(); cmd_clr = 1'b0;
        vectors++; if (is_reset !== 1'b1) begin errors++; $display("FAIL clr_stop_is_reset: got %b, expected 1", is_reset); end
        tick();
        vectors++; if (is_reset !== 1'b0) begin errors++; $display("FAIL clr_stop_width: got %b, expected 0", is_reset); end
        run_to(c + 25);
        cmd_ss = 1'b1; tick(); cmd_ss = 1'b0;
        exp_inc.push_back(c + 35);
        run_to(c + 38);
        while (exp_inc.size() != 0) begin
            e = exp_inc.pop_front();
            vectors++;
            if (obs_inc.size() == 0) begin errors++; $display("FAIL clr_inc: got no pulse, expected at cycle %0d", e); end
            else begin
                o = obs_inc.pop_front();
                if (o !== e) begin errors++; $display("FAIL clr_inc: got cycle %0d, expected cycle %0d", o, e); end
            end
        end
        vectors++; if (obs_inc.size() != 0) begin errors++; $display("FAIL clr_extra_inc: got %0d extra, expected 0", obs_inc.size()); end
        vectors++; if (obs_rst.size() != 1) begin errors++; $display("FAIL clr_rst_count: got %0d pulses, expected 1", obs_rst.size()); end
    endtask

    task automatic test_simultaneous();
        int unsigned c, e, o;
        apply_reset();
        c = cyc;
        cmd_ss = 1'b1; tick(); cmd_ss = 1'b0;
        run_to(c + 4);
        cmd_ss = 1'b1; tick(); cmd_ss = 1'b0;
        run_to(c + 8);
        cmd_clr = 1'b1; cmd_ss = 1'b1; tick(); cmd_clr = 1'b0; cmd_ss = 1'b0;
        vectors++; if (is_reset !== 1'b1) begin errors++; $display("FAIL simul_clr_ss_is_reset: got %b, expected 1", is_reset); end
        vectors++; if (running !== 1'b0)  begin errors++; $display("FAIL simul_clr_ss_running: got %b, expected 0", running); end
        run_to(c + 12);
        cmd_lap = 1'b1; cmd_ss = 1'b1; tick(); cmd_lap = 1'b0; cmd_ss = 1'b0;
        vectors++; if (running !== 1'b1)    begin errors++; $display("FAIL simul_lap_ss_running: got %b, expected 1", running); end
        vectors++; if (lap_strobe !== 1'b0) begin errors++; $display("FAIL simul_lap_ss_strobe: got %b, expected 0", lap_strobe); end
        vectors++; if (lap_hold !== 1'b0)   begin errors++; $display("FAIL simul_lap_ss_hold: got %b, expected 0", lap_hold); end
        exp_inc.push_back(c + 22);
        run_to(c + 25);
        while (exp_inc.size() != 0) begin
            e = exp_inc.pop_front();
            vectors++;
            if (obs_inc.size() == 0) begin errors++; $display("FAIL simul_inc: got no pulse, expected at cycle %0d", e); end
            else begin
                o = obs_inc.pop_front();
                if (o !== e) begin errors++; $display("FAIL simul_inc: got cycle %0d, expected cycle %0d", o, e); end
            end
        end
        vectors++; if (obs_inc.size() != 0) begin errors++; $display("FAIL simul_extra_inc: got %0d extra, expected 0", obs_inc.size()); end
    endtask

    task automatic test_back_to_back();
        int unsigned c, e, o;
        apply_reset();
        c = cyc;
        cmd_ss = 1'b1; tick(); cmd_ss = 1'b0;
        run_to(c + 9);
        cmd_ss = 1'b1; tick(); cmd_ss = 1'b0;
        exp_inc.push_back(c + 10);
        vectors++; if (running !== 1'b0) begin errors++; $display("FAIL b2b_stop_running: got %b, expected 0", running); end
        run_to(c + 15);
        cmd_ss = 1'b1; tick(); cmd_ss = 1'b0;
        exp_inc.push_back(c + 25);
        run_to(c + 28);
        while (exp_inc.size() != 0) begin
            e = exp_inc.pop_front();
            vectors++;
            if (obs_inc.size() == 0) begin errors++; $display("FAIL b2b_inc: got no pulse, expected at cycle %0d", e); end
            else begin
                o = obs_inc.pop_front();
                if (o !== e) begin errors++; $display("FAIL b2b_inc: got cycle %0d, expected cycle %0d", o, e); end
            end
        end
        vectors++; if (obs_inc.size() != 0) begin errors++; $display("FAIL b2b_extra_inc: got %0d extra, expected 0", obs_inc.size()); end
    endtask

    task automatic test_overflow();
        int unsigned c;
        apply_reset();
        c = cyc;
        cmd_ss = 1'b1; tick(); cmd_ss = 1'b0;
        run_to(c + 3);
        cmd_lap = 1'b1; tick(); cmd_lap = 1'b0;
        run_to(c + 5);
        at_max = 1'b1;
        run_to(c + 9);
        vectors++; if (running !== 1'b1) begin errors++; $display("FAIL ovf_pre_running: got %b, expected 1", running); end
        tick();
        vectors++; if (inc !== 1'b0)      begin errors++; $display("FAIL ovf_inc: got %b, expected 0", inc); end
        vectors++; if (running !== 1'b0)  begin errors++; $display("FAIL ovf_running: got %b, expected 0", running); end
        vectors++; if (ovf !== 1'b1)      begin errors++; $display("FAIL ovf_set: got %b, expected 1", ovf); end
        vectors++; if (lap_hold !== 1'b0) begin errors++; $display("FAIL ovf_lap_hold: got %b, expected 0", lap_hold); end
        at_max = 1'b0;
        run_to(c + 12);
        vectors++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b, expected 1", ovf); end
        cmd_clr = 1'b1; tick(); cmd_clr = 1'b0;
        vectors++; if (ovf !== 1'b0)      begin errors++; $display("FAIL ovf_clear: got %b, expected 0", ovf); end
        vectors++; if (is_reset !== 1'b1) begin errors++; $display("FAIL ovf_clear_is_reset: got %b, expected 1", is_reset); end
        vectors++; if (obs_inc.size() != 0) begin errors++; $display("FAIL ovf_inc_count: got %0d pulses, expected 0", obs_inc.size()); end
    endtask

    task automatic test_async_reset();
        int unsigned c;
        apply_reset();
        c = cyc;
        cmd_ss = 1'b1; tick(); cmd_ss = 1'b0;
        run_to(c + 3);
        cmd_lap = 1'b1; tick(); cmd_lap = 1'b0;
        run_to(c + 6);
        vectors++; if (lap_hold !== 1'b1) begin errors++; $display("FAIL async_pre_hold: got %b, expected 1", lap_hold); end
        #2;
        rst = 1'b0;
        #1;
        vectors++; if (running !== 1'b0)    begin errors++; $display("FAIL async_running: got %b, expected 0", running); end
        vectors++; if (lap_hold !== 1'b0)   begin errors++; $display("FAIL async_lap_hold: got %b, expected 0", lap_hold); end
        vectors++; if (inc !== 1'b0)        begin errors++; $display("FAIL async_inc: got %b, expected 0", inc); end
        vectors++; if (is_reset !== 1'b0)   begin errors++; $display("FAIL async_is_reset: got %b, expected 0", is_reset); end
        vectors++; if (lap_strobe !== 1'b0) begin errors++; $display("FAIL async_lap_strobe: got %b, expected 0", lap_strobe); end
        vectors++; if (ovf !== 1'b0)        begin errors++; $display("FAIL async_ovf: got %b, expected 0", ovf); end
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_exclusive();
        vectors++;
        if (both_seen !== 1'b0) begin errors++; $display("FAIL inc_is_reset_overlap: got %b, expected 0", both_seen); end
    endtask

    initial begin
        test_reset();
        test_basic_run();
        test_stop_resume();
        test_lap();
        test_clear();
        test_simultaneous();
        test_back_to_back();
        test_overflow();
        test_async_reset();
        test_exclusive();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
